// File: rtl/tetris_pkg.sv
// Shared playfield types and constants for the Tetris board pipeline.
// Used by the line-clear scanner and the board manager.
package tetris_pkg;

  localparam int BOARD_COLS     = 10;
  localparam int BOARD_ROWS_DEF = 20;

  typedef logic [15:0] cell_t;

  localparam cell_t EMPTY_COLOR = 16'h000F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_EVAL,
    S_REPORT,
    S_WAIT_CLR
  } lcs_state_e;

endpackage

// File: rtl/row_full_check.sv
// Combinational full/empty classification of one board row.
// Shared between the line-clear scanner and the board manager.
module row_full_check
  import tetris_pkg::*;
(
  input  cell_t cells [BOARD_COLS],
  output logic  is_full,
  output logic  is_empty
);

  always_comb begin
    is_full  = 1'b1;
    is_empty = 1'b1;
    for (int i = 0; i < BOARD_COLS; i++) begin
      if (cells[i] == EMPTY_COLOR) begin
        is_full = 1'b0;
      end else begin
        is_empty = 1'b0;
      end
    end
  end

endmodule

// File: rtl/line_clear_scanner.sv
// Bottom-up full-row scanner feeding the board manager's row-copy engine.
// LCS_EARLY_STOP_EN: stop the scan at the first all-empty row.
module line_clear_scanner
  import tetris_pkg::*;
#(
  parameter int BOARD_ROWS     = BOARD_ROWS_DEF,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        row_ready,
  input  cell_t       row_data [BOARD_COLS],
  input  logic        clear_done,
  output logic        row_ld,
  output logic [7:0]  row,
  output logic        busy,
  output logic        clear_valid,
  output logic [7:0]  clear_row,
  output logic [7:0]  clear_num_rows,
  output logic [15:0] lines_total,
  output logic        timeout_err
);

  localparam int TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [7:0]    TOP_ROW = 8'(BOARD_ROWS - 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

  lcs_state_e    state_q, state_d;
  logic [7:0]    row_q, row_d;
  logic [7:0]    run_q, run_d;
  logic [TW-1:0] tmo_q, tmo_d;
  cell_t         rowbuf_q [BOARD_COLS];
  cell_t         rowbuf_d [BOARD_COLS];
  logic [7:0]    crow_q, crow_d;
  logic [7:0]    cnum_q, cnum_d;
  logic          cvld_q, cvld_d;
  logic [15:0]   lines_q, lines_d;
  logic          terr_q, terr_d;

  logic          row_full;
  logic          row_empty;
  logic [16:0]   lines_sum;

  row_full_check u_chk (
    .cells    (rowbuf_q),
    .is_full  (row_full),
    .is_empty (row_empty)
  );

`ifndef LCS_EARLY_STOP_EN
  logic unused_empty;
  assign unused_empty = row_empty;
`endif

  assign lines_sum = {1'b0, lines_q} + {9'd0, cnum_q};

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    run_d    = run_q;
    tmo_d    = tmo_q;
    rowbuf_d = rowbuf_q;
    crow_d   = crow_q;
    cnum_d   = cnum_q;
    cvld_d   = cvld_q;
    lines_d  = lines_q;
    terr_d   = terr_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          row_d   = TOP_ROW;
          run_d   = '0;
          terr_d  = 1'b0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (row_ready) begin
          rowbuf_d = row_data;
          state_d  = S_EVAL;
        end else if (tmo_q == TMO_MAX) begin
          terr_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_EVAL: begin
        if (row_full) begin
          if (run_q == 8'd0) crow_d = row_q;
          run_d = run_q + 8'd1;
        end
        if (!row_full && run_q != 8'd0) begin
          state_d = S_REPORT;
`ifdef LCS_EARLY_STOP_EN
        end else if (row_empty || row_q == 8'd0) begin
`else
        end else if (row_q == 8'd0) begin
`endif
          state_d = (run_d != 8'd0) ? S_REPORT : S_IDLE;
        end else begin
          row_d   = row_q - 8'd1;
          state_d = S_REQ;
        end
      end
      S_REPORT: begin
        cnum_d  = run_q;
        cvld_d  = 1'b1;
        state_d = S_WAIT_CLR;
      end
      S_WAIT_CLR: begin
        if (clear_done) begin
          cvld_d  = 1'b0;
          lines_d = lines_sum[16] ? 16'hFFFF : lines_sum[15:0];
          row_d   = TOP_ROW;
          run_d   = '0;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      row_q    <= '0;
      run_q    <= '0;
      tmo_q    <= '0;
      rowbuf_q <= '{default: '0};
      crow_q   <= '0;
      cnum_q   <= '0;
      cvld_q   <= 1'b0;
      lines_q  <= '0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      run_q    <= run_d;
      tmo_q    <= tmo_d;
      rowbuf_q <= rowbuf_d;
      crow_q   <= crow_d;
      cnum_q   <= cnum_d;
      cvld_q   <= cvld_d;
      lines_q  <= lines_d;
      terr_q   <= terr_d;
    end
  end

  // Held while the manager is busy so a request is never dropped.
  assign row_ld         = (state_q == S_WAIT) && !row_ready;
  assign row            = row_q;
  assign busy           = (state_q != S_IDLE);
  assign clear_valid    = cvld_q;
  assign clear_row      = crow_q;
  assign clear_num_rows = cnum_q;
  assign lines_total    = lines_q;
  assign timeout_err    = terr_q;

endmodule

// File: doc/line_clear_scanner.md
Name: line_clear_scanner

Overview:
- Sits upstream of the VRAM/SDRAM board manager and consumes its row-read service.
- After a piece locks, it requests board rows one at a time, bottom to top, and checks whether each row is full.
- It finds the lowest contiguous run of full rows and presents it as clear_row / clear_num_rows / clear_valid to the manager's row-copy engine.
- It keeps a running line count for scoring.

Parameters:
- BOARD_ROWS, 20, rows in the playfield; row index 0 is the top.
- TIMEOUT_CYCLES, 4096, maximum cycles to wait for row_ready before aborting.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle pulse on piece lock; begins a scan
- row_ready  in  1  pulse from the board manager: row_data is valid
- row_data  in  16 x [10]  cell colours of the requested row (unpacked array)
- clear_done  in  1  pulse from the board manager: requested clear finished
- row_ld  out  1  row read request
- row  out  8  row index being requested
- busy  out  1  high whenever state is not IDLE
- clear_valid  out  1  clear request, held until clear_done
- clear_row  out  8  bottom-most row of the full run
- clear_num_rows  out  8  length of the full run (1..4 in play)
- lines_total  out  16  saturating count of cleared lines
- timeout_err  out  1  sticky; set on row_ready timeout, cleared by the next start

Behaviour:
- Reset values: all outputs 0; state IDLE; internal counters 0. Reset asserted mid-operation aborts immediately, and row_ld falls asynchronously.
- States: IDLE, REQ, WAIT, EVAL, REPORT, WAIT_CLR.
- IDLE:
  - start=1 -> row <= BOARD_ROWS-1, run_len <= 0, timeout_err <= 0, go to REQ.
  - start while not IDLE is ignored.
- REQ: clear the timeout counter, go to WAIT (1 cycle).
- WAIT:
  - row_ld = (state==WAIT) && !row_ready, computed combinationally. It is held until the manager responds, so a request made while the manager is busy is not lost.
  - row_ready=1 -> latch row_data into the row register, go to EVAL.
  - Timeout counter reaches TIMEOUT_CYCLES-1 -> timeout_err <= 1, go to IDLE.
- EVAL: full = every cell != EMPTY_COLOR (16'h000F).
  - full and run_len==0 -> clear_row <= row, run_len <= 1.
  - full and run_len>0 -> run_len <= run_len+1.
  - not full and run_len>0 -> go to REPORT. The run has ended.
  - not full and run_len==0 -> continue scanning.
  - row==0 -> go to REPORT if run_len>0, else IDLE. No wrap-around below 0.
  - Otherwise -> row <= row-1, go to REQ.
- REPORT: clear_num_rows <= run_len, clear_valid <= 1, go to WAIT_CLR.
- WAIT_CLR:
  - clear_row, clear_num_rows and clear_valid are stable while waiting.
  - clear_done=1 -> clear_valid <= 0; lines_total <= min(lines_total + clear_num_rows, 16'hFFFF).
  - Then rescan: row <= BOARD_ROWS-1, run_len <= 0, go to REQ. Non-contiguous full rows are caught by the rescan.
- Latency per row: REQ(1) + WAIT (manager latency) + EVAL(1).
- Simultaneous start and clear_done in WAIT_CLR: clear_done is handled and start is ignored.
- row_ready outside WAIT is ignored.

Optional Feature:
- Macro: LCS_EARLY_STOP_EN.
- Defined: in EVAL, a row whose cells all equal EMPTY_COLOR terminates the scan. Go to REPORT if run_len>0, else IDLE. Rows above an empty row cannot hold blocks.
- Undefined: every scan walks all BOARD_ROWS rows, down to row 0.

Decomposition:
- Shared package tetris_pkg holds: BOARD_COLS=10, BOARD_ROWS_DEF=20, EMPTY_COLOR=16'h000F, cell_t (logic [15:0]), and the scanner state enum.
- One sub-module, row_full_check: a combinational compare over the 10 cells, outputs is_full and is_empty. It is reusable by the board manager.

Test Plan:
- Empty board (all cells 16'h000F), start -> 20 row_ld handshakes for rows 19..0, no clear_valid, back to IDLE. With LCS_EARLY_STOP_EN: exactly 1 handshake (row 19).
- Rows 19 and 18 full, row 17 partial, start -> clear_valid with clear_row=19, clear_num_rows=2. After clear_done with board updated -> rescan finds nothing, lines_total=2.
- Rows 19 and 17 full, row 18 partial -> first report clear_row=19, num=1. Model a one-row shift, rescan -> clear_row=18, num=1. lines_total=2.
- Hold row_ready low for 4096 cycles after a request -> timeout_err=1, state IDLE, row_ld=0. The next start clears timeout_err.
- Preload lines_total=16'hFFFE, clear a run of 4 -> lines_total=16'hFFFF (saturates).
- Assert reset during WAIT with row_ld=1 -> row_ld=0 immediately, all outputs 0. A start pulse during a scan has no effect.
